// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: 16-way grant/hold/release arbiter with fixed or round-robin
// priority and an optional hold limit that forces the owner off the resource.
module rr_grant_arbiter #(
    parameter int N        = 16,
    parameter int MAX_HOLD = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    input  logic         rr_en_i,
    input  logic         release_i,
    output logic [N-1:0] gnt_o,
    output logic         gnt_valid_o,
    output logic [3:0]   gnt_idx_o,
    output logic         preempt_o
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t       state_q, state_d;
    logic [N-1:0] gnt_q, gnt_d;
    logic [3:0]   idx_q, idx_d, last_q, last_d, base, cand, w;
    logic [7:0]   cnt_q, cnt_d;
    logic         preempt_q, preempt_d, user_end, limit;
    // Walk last-16 .. last-1 so the candidate nearest below last is written last and wins.
    always_comb begin
        base = rr_en_i ? last_q : 4'd0;
        w    = 4'd0;
        cand = 4'd0;
        for (int k = 16; k >= 1; k--) begin
            cand = base - 4'(k);
            if (req_i[cand]) w = cand;
        end
    end
    assign limit    = (MAX_HOLD != 0) && (cnt_q == 8'(MAX_HOLD - 1));
    assign user_end = release_i || !req_i[idx_q];
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        preempt_d = 1'b0;
        if (state_q == IDLE) begin
            if (|req_i) begin
                state_d = GRANT;
                gnt_d   = {{(N-1){1'b0}}, 1'b1} << w;
                idx_d   = w;
                last_d  = w;
                cnt_d   = 8'd0;
            end
        end else begin
            cnt_d = (cnt_q == 8'd255) ? cnt_q : cnt_q + 8'd1;
            if (user_end || limit) begin
                state_d   = IDLE;
                gnt_d     = '0;
                idx_d     = 4'd0;
                preempt_d = limit && !user_end;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            idx_q     <= 4'd0;
            last_q    <= 4'd0;
            cnt_q     <= 8'd0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            preempt_q <= preempt_d;
        end
    end
    assign gnt_o       = gnt_q;
    assign gnt_valid_o = (state_q == GRANT);
    assign gnt_idx_o   = idx_q;
    assign preempt_o   = preempt_q;
endmodule
